scan_ctrl: RTL and testbench

SCAN_CTRL -- requirements
Module: scan_ctrl

---
 rtl/scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_scan_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - scan chain load/capture/unload sequencer (optional compare: SCAN_CTRL_CMP_EN)
module scan_ctrl #(
    parameter int CHAIN_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pattern,
    input  logic [7:0] expected,
    input  logic       SDO,
    output logic       m,
    output logic       SDI,
    output logic       busy,
    output logic       done,
    output logic [7:0] captured,
    output logic       pass
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    // Counter value of the final cycle of a shift phase.
    localparam logic [2:0] LAST_BIT = 3'(CHAIN_LEN - 1);
    // Keeps captured bits above the chain length at zero.
    localparam logic [7:0] CAP_MASK = 8'((9'd1 << CHAIN_LEN) - 9'd1);

    state_t                 state;
    state_t                 state_nx;
    logic [2:0]             cnt;
    logic [2:0]             cnt_nx;
    logic [CHAIN_LEN-1:0]   pat_sh;
    logic [CHAIN_LEN-1:0]   pat_nx;
    logic [CHAIN_LEN-1:0]   pat_shl;
    logic [7:0]             cap_nx;
    logic                   m_nx;
    logic                   sdi_nx;
    logic                   done_nx;
    logic                   pass_upd;
    logic                   pass_clr;

    // Pattern and compare bits above the chain length are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{pattern, expected};

    // Pattern bit that goes out on SDI next cycle, MSB first.
    assign pat_shl = pat_sh << 1;

    // Next-state decode; outputs are computed for the next state so the registers line up with it.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pat_nx   = pat_sh;
        cap_nx   = captured;
        m_nx     = 1'b0;
        sdi_nx   = 1'b0;
        done_nx  = 1'b0;
        pass_upd = 1'b0;
        pass_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT_IN;
                    cnt_nx   = 3'd0;
                    pat_nx   = pattern[CHAIN_LEN-1:0];
                    cap_nx   = 8'd0;
                    pass_clr = 1'b1;
                    m_nx     = 1'b1;
                    sdi_nx   = pattern[CHAIN_LEN-1];
                end
            end
            SHIFT_IN: begin
                if (cnt == LAST_BIT) begin
                    state_nx = CAPTURE;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                    pat_nx = pat_shl;
                    m_nx   = 1'b1;
                    sdi_nx = pat_shl[CHAIN_LEN-1];
                end
            end
            CAPTURE: begin
                state_nx = SHIFT_OUT;
                cnt_nx   = 3'd0;
                m_nx     = 1'b1;
            end
            SHIFT_OUT: begin
                // First sample migrates up to captured[CHAIN_LEN-1].
                cap_nx = {captured[6:0], SDO} & CAP_MASK;
                if (cnt == LAST_BIT) begin
                    state_nx = DONE;
                    cnt_nx   = 3'd0;
                    done_nx  = 1'b1;
                    pass_upd = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                    m_nx   = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    // State, counter, shift data and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            pat_sh   <= '0;
            captured <= 8'd0;
            m        <= 1'b0;
            SDI      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pat_sh   <= pat_nx;
            captured <= cap_nx;
            m        <= m_nx;
            SDI      <= sdi_nx;
            busy     <= (state_nx != IDLE);
            done     <= done_nx;
        end
    end

`ifdef SCAN_CTRL_CMP_EN
    logic pass_q;

    // Compare result uses the value captured on the final unload edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (pass_clr) begin
            pass_q <= 1'b0;
        end else if (pass_upd) begin
            pass_q <= (cap_nx[CHAIN_LEN-1:0] == expected[CHAIN_LEN-1:0]);
        end
    end

    assign pass = pass_q;
`else
    logic unused_cmp;
    assign unused_cmp = pass_upd ^ pass_clr;
    assign pass       = 1'b0;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - bench for scan_ctrl with CHAIN_LEN 3 and 1 and behavioural chain models
module tb_scan_ctrl;

`ifdef SCAN_CTRL_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start_a = 1'b0;
    logic [7:0] pattern_a = 8'd0;
    logic [7:0] expected_a = 8'd0;
    logic       sdo_a;
    logic       m_a, sdi_a, busy_a, done_a, pass_a;
    logic [7:0] captured_a;
    logic [2:0] chain_a = 3'd0;
    logic [2:0] load_a = 3'd0;

    logic       start_b = 1'b0;
    logic [7:0] pattern_b = 8'd0;
    logic [7:0] expected_b = 8'd0;
    logic       sdo_b;
    logic       m_b, sdi_b, busy_b, done_b, pass_b;
    logic [7:0] captured_b;
    logic       chain_b = 1'b0;
    logic       load_b = 1'b0;

    int vectors = 0;
    int errors  = 0;

    scan_ctrl #(.CHAIN_LEN(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .pattern(pattern_a), .expected(expected_a),
        .SDO(sdo_a), .m(m_a), .SDI(sdi_a), .busy(busy_a), .done(done_a),
        .captured(captured_a), .pass(pass_a)
    );

    scan_ctrl #(.CHAIN_LEN(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .pattern(pattern_b), .expected(expected_b),
        .SDO(sdo_b), .m(m_b), .SDI(sdi_b), .busy(busy_b), .done(done_b),
        .captured(captured_b), .pass(pass_b)
    );

    always #5 clk = ~clk;

    // Scan chains: shift from SDI toward SDO when m=1, load functional value when m=0.
    always @(posedge clk) begin
        if (m_a) chain_a <= {chain_a[1:0], sdi_a};
        else     chain_a <= load_a;
        if (m_b) chain_b <= sdi_b;
        else     chain_b <= load_b;
    end
    assign sdo_a = chain_a[2];
    assign sdo_b = chain_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // One full test on instance a (sel=0, 3 stages) or b (sel=1, 1 stage).
    task automatic run(input bit sel, input logic [7:0] pat, input logic [7:0] load,
                       input logic [7:0] exp_v, input bit extra);
        int n;
        logic [7:0] mask, exp_cap, exp_chain;
        logic exp_pass;
        logic om, osdi, obusy, odone, opass;
        logic [7:0] ocap, ochain;
        n         = sel ? 1 : 3;
        mask      = 8'((1 << n) - 1);
        exp_cap   = load & mask;
        exp_chain = pat & mask;
        exp_pass  = CMP_EN && ((exp_v & mask) == exp_cap);
        if (sel) begin pattern_b = pat; load_b = load[0]; expected_b = exp_v; end
        else begin pattern_a = pat; load_a = load[2:0]; expected_a = exp_v; end
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int k = 1; k <= 2 * n + 2; k++) begin
            @(negedge clk);
            set_start(sel, (extra && k == n + 3) ? 1'b1 : 1'b0);
            om     = sel ? m_b : m_a;
            osdi   = sel ? sdi_b : sdi_a;
            obusy  = sel ? busy_b : busy_a;
            odone  = sel ? done_b : done_a;
            ochain = sel ? {7'd0, chain_b} : {5'd0, chain_a};
            chk("m", {31'd0, om}, {31'd0, (k <= n) || (k >= n + 2 && k <= 2 * n + 1)});
            chk("sdi", {31'd0, osdi}, {31'd0, (k <= n) ? pat[n - k] : 1'b0});
            chk("busy", {31'd0, obusy}, 32'd1);
            chk("done", {31'd0, odone}, {31'd0, k == 2 * n + 2});
            if (k == n + 1) chk("chain_loaded", {24'd0, ochain}, {24'd0, exp_chain});
        end
        ocap  = sel ? captured_b : captured_a;
        opass = sel ? pass_b : pass_a;
        chk("captured", {24'd0, ocap}, {24'd0, exp_cap});
        chk("pass", {31'd0, opass}, {31'd0, exp_pass});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_start(sel, 1'b0);
            obusy = sel ? busy_b : busy_a;
            odone = sel ? done_b : done_a;
            ocap  = sel ? captured_b : captured_a;
            opass = sel ? pass_b : pass_a;
            chk("idle_done", {31'd0, odone}, 32'd0);
            chk("idle_busy", {31'd0, obusy}, 32'd0);
            chk("hold_captured", {24'd0, ocap}, {24'd0, exp_cap});
            chk("hold_pass", {31'd0, opass}, {31'd0, exp_pass});
        end
    endtask

    initial begin
        logic [7:0] p, l, e;
        int seen_done;
        #1;
        chk("rst_m", {30'd0, m_a, m_b}, 32'd0);
        chk("rst_sdi", {30'd0, sdi_a, sdi_b}, 32'd0);
        chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("rst_done", {30'd0, done_a, done_b}, 32'd0);
        chk("rst_pass", {30'd0, pass_a, pass_b}, 32'd0);
        chk("rst_captured", {16'd0, captured_a, captured_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 8'b0000_0101, 8'b110, 8'h00, 1'b0);
        run(1'b0, 8'hA5, 8'b011, 8'b011, 1'b0);
        run(1'b0, 8'hA5, 8'b011, 8'b010, 1'b0);
        run(1'b0, 8'b0000_0110, 8'b101, 8'hF5, 1'b1);
        run(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0);
        run(1'b1, 8'h00, 8'h00, 8'hFE, 1'b1);

        // Reset during the second shift-in cycle aborts the test asynchronously.
        @(negedge clk);
        pattern_a = 8'h07;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_m", {31'd0, m_a}, 32'd0);
        chk("abort_sdi", {31'd0, sdi_a}, 32'd0);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_done", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        run(1'b0, 8'h02, 8'b100, 8'h04, 1'b0);

        for (int i = 0; i < 14; i++) begin
            p = 8'($urandom);
            l = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? {5'($urandom), l[2:0]} : 8'($urandom);
            run(1'b0, p, l, e, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) begin
            p = 8'($urandom);
            l = 8'($urandom);
            e = 8'($urandom);
            run(1'b1, p, l, e, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
